// File: rtl/decrement_timer.sv
// Loadable N-bit down-counter with a one-cycle done pulse on reaching zero.
// Optional periodic mode: define DECREMENT_TIMER_AUTO_RELOAD_EN to restart from the last load.
module decrement_timer #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         abort,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;

`ifdef DECREMENT_TIMER_AUTO_RELOAD_EN
  logic [N-1:0] reload_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else if (load && !abort) begin
      reload_q <= load_val;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (abort) begin
      state_d = StIdle;
      count_d = '0;
    end else if (load) begin
      if (load_val != '0) begin
        state_d = StRun;
        count_d = load_val;
      end else begin
        state_d = StDone;
        count_d = '0;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (en) begin
            // RUN never holds 0, so count<=1 is the final decrement.
            if (count_q > N'(1)) begin
              count_d = count_q - N'(1);
            end else begin
              count_d = '0;
              state_d = StDone;
            end
          end
        end
        StDone: begin
`ifdef DECREMENT_TIMER_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            state_d = StRun;
            count_d = reload_q;
          end else begin
            state_d = StDone;
            count_d = '0;
          end
`else
          state_d = StIdle;
`endif
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);

endmodule
